// File: rtl/mem_write_checker.sv
// Checks a CPU's store stream against a small table of expected (address, data) writes.
// A run passes once num_exp writes match in order, and fails on timeout or (STRICT) a stray write.
module mem_write_checker #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024,
  parameter int STRICT  = 0,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NW = $clog2(DEPTH + 1),
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_idx,
  input  logic [XLEN-1:0] cfg_addr,
  input  logic [XLEN-1:0] cfg_data,
  input  logic [NW-1:0]   num_exp,
  input  logic            start,
  input  logic            memwrite,
  input  logic [XLEN-1:0] dataadr,
  input  logic [XLEN-1:0] writedata,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [1:0]      fail_code,
  output logic [NW-1:0]   match_count,
  output logic [7:0]      mismatch_count,
  output logic [CW-1:0]   cycle_count
);

  // state  | meaning
  // IDLE   | waiting for start after reset
  // RUN    | comparing stores against the table, counting cycles
  // PASS   | all expected writes seen in order (sticky)
  // FAIL   | stray write (STRICT) or timeout (sticky)
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  localparam logic [NW-1:0]   DEPTH_N  = NW'(DEPTH);
  localparam logic [CW-1:0]   LAST_CYC = CW'(TIMEOUT - 1);
  localparam logic [AW:0]     DEPTH_I  = (AW + 1)'(DEPTH);
  localparam logic [1:0]      FC_NONE  = 2'b00;
  localparam logic [1:0]      FC_MISM  = 2'b01;
  localparam logic [1:0]      FC_TMO   = 2'b10;

  state_t          state_q, state_d;
  logic [NW-1:0]   nexp_q, nexp_d;
  logic [NW-1:0]   match_q, match_d;
  logic [7:0]      mis_q, mis_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [1:0]      fc_q, fc_d;

  logic [XLEN-1:0] exp_addr [DEPTH];
  logic [XLEN-1:0] exp_data [DEPTH];

  logic [NW-1:0]   nexp_clamped;
  logic [AW-1:0]   cur_idx;
  logic [NW-1:0]   match_inc;
  logic            hit;
  logic            last_cycle;

  assign nexp_clamped = (num_exp > DEPTH_N) ? DEPTH_N : num_exp;
  assign cur_idx      = match_q[AW-1:0];
  assign match_inc    = match_q + NW'(1);
  assign hit          = (dataadr == exp_addr[cur_idx]) && (writedata == exp_data[cur_idx]);
  assign last_cycle   = (cyc_q == LAST_CYC);

  // Table is deliberately not reset so software can reload it at will.
  always_ff @(posedge clk) begin
    if (cfg_we && (state_q != S_RUN) && ({1'b0, cfg_idx} < DEPTH_I)) begin
      exp_addr[cfg_idx] <= cfg_addr;
      exp_data[cfg_idx] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      nexp_q  <= '0;
      match_q <= '0;
      mis_q   <= '0;
      cyc_q   <= '0;
      fc_q    <= FC_NONE;
    end else begin
      state_q <= state_d;
      nexp_q  <= nexp_d;
      match_q <= match_d;
      mis_q   <= mis_d;
      cyc_q   <= cyc_d;
      fc_q    <= fc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    nexp_d  = nexp_q;
    match_d = match_q;
    mis_d   = mis_q;
    cyc_d   = cyc_q;
    fc_d    = fc_q;

    if (start) begin
      // Any start (including mid-run) begins a fresh run; that cycle's store is ignored.
      state_d = S_RUN;
      nexp_d  = nexp_clamped;
      match_d = '0;
      mis_d   = '0;
      cyc_d   = '0;
      fc_d    = FC_NONE;
    end else if (state_q == S_RUN) begin
      if (!last_cycle) begin
        cyc_d = cyc_q + CW'(1);
      end
      if (nexp_q == '0) begin
        state_d = S_PASS;
      end else if (memwrite && hit) begin
        match_d = match_inc;
        if (match_inc == nexp_q) begin
          state_d = S_PASS;
        end else if (last_cycle) begin
          state_d = S_FAIL;
          fc_d    = FC_TMO;
        end
      end else if (memwrite && (STRICT != 0)) begin
        state_d = S_FAIL;
        fc_d    = FC_MISM;
      end else begin
        if (memwrite && (mis_q != 8'hFF)) begin
          mis_d = mis_q + 8'd1;
        end
        if (last_cycle) begin
          state_d = S_FAIL;
          fc_d    = FC_TMO;
        end
      end
    end
  end

  assign busy           = (state_q == S_RUN);
  assign done           = (state_q == S_PASS) || (state_q == S_FAIL);
  assign pass           = (state_q == S_PASS);
  assign fail_code      = fc_q;
  assign match_count    = match_q;
  assign mismatch_count = mis_q;
  assign cycle_count    = cyc_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Drives a lenient and a strict checker with the same stimulus and compares both
// every cycle against a behavioural model of the run rules.
module tb_mem_write_checker;
  localparam int TMO = 16;
  localparam int DEP = 4;

  logic        clk = 0;
  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_addr, cfg_data;
  logic [2:0]  num_exp;
  logic        start, memwrite;
  logic [31:0] dataadr, writedata;

  logic       busy [2], done [2], pass [2];
  logic [1:0] fc [2];
  logic [2:0] mc [2];
  logic [7:0] mis [2];
  logic [4:0] cyc [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_write_checker #(.XLEN(32), .DEPTH(DEP), .TIMEOUT(TMO), .STRICT(g)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .num_exp(num_exp), .start(start),
      .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
      .busy(busy[g]), .done(done[g]), .pass(pass[g]), .fail_code(fc[g]),
      .match_count(mc[g]), .mismatch_count(mis[g]), .cycle_count(cyc[g]));
  end

  always #5 clk = ~clk;

  // Model: st 0=idle 1=running 2=passed 3=failed
  typedef struct {
    int st; int ne; int mc; int mis; int cyc; int fc;
  } m_t;
  m_t          m [2];
  logic [31:0] ta [2][DEP];
  logic [31:0] td [2][DEP];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int k, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[dut%0d] at %0t: got %0d want %0d", name, k, $time, act, exp);
    end
  endtask

  task automatic model_clear(input int k);
    m[k] = '{default: 0};
  endtask

  task automatic step(input int k);
    int  used;
    bit  timed_out;
    if (cfg_we && m[k].st != 1 && int'(cfg_idx) < DEP) begin
      ta[k][cfg_idx] = cfg_addr;
      td[k][cfg_idx] = cfg_data;
    end
    if (start) begin
      model_clear(k);
      m[k].st = 1;
      m[k].ne = (int'(num_exp) > DEP) ? DEP : int'(num_exp);
      return;
    end
    if (m[k].st != 1) return;
    used = m[k].cyc;
    timed_out = (used >= TMO - 1);
    m[k].cyc = timed_out ? used : used + 1;
    if (m[k].ne == 0) begin
      m[k].st = 2;
      return;
    end
    if (memwrite) begin
      if (dataadr == ta[k][m[k].mc] && writedata == td[k][m[k].mc]) begin
        m[k].mc++;
        if (m[k].mc == m[k].ne) begin
          m[k].st = 2;
          return;
        end
      end else if (k == 1) begin
        m[k].st = 3;
        m[k].fc = 1;
        return;
      end else if (m[k].mis < 255) begin
        m[k].mis++;
      end
    end
    if (timed_out) begin
      m[k].st = 3;
      m[k].fc = 2;
    end
  endtask

  always @(posedge clk) if (reset === 1'b1) for (int k = 0; k < 2; k++) step(k);
  always @(negedge reset) for (int k = 0; k < 2; k++) model_clear(k);

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check("busy", k, int'(busy[k]), int'(m[k].st == 1));
      check("done", k, int'(done[k]), int'(m[k].st >= 2));
      check("pass", k, int'(pass[k]), int'(m[k].st == 2));
      check("fail_code", k, int'(fc[k]), m[k].fc);
      check("match_count", k, int'(mc[k]), m[k].mc);
      check("mismatch_count", k, int'(mis[k]), m[k].mis);
      check("cycle_count", k, int'(cyc[k]), m[k].cyc);
    end
  end

  task automatic cyc_t();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int idx, input logic [31:0] a, input logic [31:0] d);
    cfg_we = 1; cfg_idx = 2'(idx); cfg_addr = a; cfg_data = d;
    cyc_t();
    cfg_we = 0;
  endtask

  task automatic run_start(input int n);
    num_exp = 3'(n); start = 1;
    cyc_t();
    start = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1; dataadr = a; writedata = d;
    cyc_t();
    memwrite = 0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      model_clear(k);
      for (int i = 0; i < DEP; i++) begin ta[k][i] = '0; td[k][i] = '0; end
    end
    reset = 0; cfg_we = 0; cfg_idx = 0; cfg_addr = 0; cfg_data = 0;
    num_exp = 0; start = 0; memwrite = 0; dataadr = 0; writedata = 0;
    cyc_t(); cyc_t();
    for (int k = 0; k < 2; k++) begin
      check("rst_busy", k, int'(busy[k]), 0);
      check("rst_done", k, int'(done[k]), 0);
      check("rst_cycle", k, int'(cyc[k]), 0);
    end
    reset = 1;
    cyc_t();

    // Two-entry sequence, both instances pass
    cfg(0, 32'h80, 32'd7);
    cfg(1, 32'h84, 32'd7);
    run_start(2);
    wr(32'h80, 32'd7);
    for (int k = 0; k < 2; k++) check("seq_mid_busy", k, int'(busy[k]), 1);
    wr(32'h84, 32'd7);
    for (int k = 0; k < 2; k++) begin
      check("seq_pass", k, int'(pass[k]), 1);
      check("seq_match", k, int'(mc[k]), 2);
      check("seq_fc", k, int'(fc[k]), 0);
    end

    // Stray write: lenient counts it, strict fails
    run_start(2);
    wr(32'h80, 32'd7);
    wr(32'h88, 32'd3);
    check("strict_fc", 1, int'(fc[1]), 1);
    check("strict_match", 1, int'(mc[1]), 1);
    check("strict_done", 1, int'(done[1]), 1);
    wr(32'h84, 32'd7);
    check("lenient_pass", 0, int'(pass[0]), 1);
    check("lenient_mis", 0, int'(mis[0]), 1);
    check("strict_still_fail", 1, int'(pass[1]), 0);

    // Timeout
    run_start(1);
    repeat (15) cyc_t();
    for (int k = 0; k < 2; k++) begin
      check("tmo_pre_busy", k, int'(busy[k]), 1);
      check("tmo_pre_cyc", k, int'(cyc[k]), 15);
    end
    cyc_t();
    for (int k = 0; k < 2; k++) begin
      check("tmo_fc", k, int'(fc[k]), 2);
      check("tmo_cyc", k, int'(cyc[k]), 15);
      check("tmo_pass", k, int'(pass[k]), 0);
    end
    run_start(1);
    for (int k = 0; k < 2; k++) begin
      check("restart_busy", k, int'(busy[k]), 1);
      check("restart_cyc", k, int'(cyc[k]), 0);
      check("restart_fc", k, int'(fc[k]), 0);
    end

    // Zero expected writes, started from within a run
    run_start(0);
    cyc_t();
    for (int k = 0; k < 2; k++) check("zero_pass", k, int'(pass[k]), 1);

    // num_exp above DEPTH clamps to DEPTH
    cfg(2, 32'h88, 32'd3);
    cfg(3, 32'h8C, 32'd3);
    run_start(7);
    wr(32'h80, 32'd7); wr(32'h84, 32'd7); wr(32'h88, 32'd3);
    for (int k = 0; k < 2; k++) check("clamp_mid_match", k, int'(mc[k]), 3);
    wr(32'h8C, 32'd3);
    for (int k = 0; k < 2; k++) begin
      check("clamp_pass", k, int'(pass[k]), 1);
      check("clamp_match", k, int'(mc[k]), 4);
    end

    // Completing match on the last allowed cycle wins over timeout
    run_start(1);
    repeat (15) cyc_t();
    wr(32'h80, 32'd7);
    for (int k = 0; k < 2; k++) begin
      check("edge_pass", k, int'(pass[k]), 1);
      check("edge_fc", k, int'(fc[k]), 0);
      check("edge_cyc", k, int'(cyc[k]), 15);
    end

    // Asynchronous reset mid-run, table retained afterwards
    run_start(2);
    wr(32'h80, 32'd7);
    cyc_t();
    #2 reset = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("arst_busy", k, int'(busy[k]), 0);
      check("arst_done", k, int'(done[k]), 0);
      check("arst_match", k, int'(mc[k]), 0);
      check("arst_cyc", k, int'(cyc[k]), 0);
    end
    cyc_t();
    reset = 1;
    run_start(1);
    wr(32'h80, 32'd7);
    for (int k = 0; k < 2; k++) check("retained_pass", k, int'(pass[k]), 1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int sel;
      reset     = 1;
      cfg_we    = ($urandom % 4 == 0);
      cfg_idx   = 2'($urandom);
      cfg_addr  = 32'h80 + 32'(4 * ($urandom % 4));
      cfg_data  = ($urandom % 2) ? 32'd7 : 32'd3;
      num_exp   = 3'($urandom);
      start     = ($urandom % 30 == 0);
      memwrite  = ($urandom % 2 == 0);
      sel       = int'($urandom % 8);
      if (sel < 4 && m[0].mc < DEP) begin
        dataadr = ta[0][m[0].mc]; writedata = td[0][m[0].mc];
      end else if (sel == 4 && m[0].mc < DEP) begin
        dataadr = ta[0][m[0].mc] ^ (32'd1 << ($urandom % 32)); writedata = td[0][m[0].mc];
      end else if (sel == 5 && m[0].mc < DEP) begin
        dataadr = ta[0][m[0].mc]; writedata = td[0][m[0].mc] ^ (32'd1 << ($urandom % 32));
      end else begin
        dataadr = 32'h80 + 32'(4 * ($urandom % 4)); writedata = $urandom;
      end
      if ($urandom % 300 == 0) begin
        #2 reset = 0;
      end
      cyc_t();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
